// File: rtl/cat_rec_pkg.sv
// Shared types and register/memory map for the cat_recognizer APB space.
// The requester and the bench both import this package.
package cat_rec_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

    localparam int          CAT_REC_ADDR_W = 13;
    localparam logic [12:0] CTRL_ADDR      = 13'h0000;
    localparam logic [12:0] STATUS_ADDR    = 13'h0001;
    localparam logic [12:0] WEIGHT_BASE    = 13'h0010;
    localparam logic [12:0] IMAGE_BASE     = 13'h0400;

endpackage

// File: rtl/cat_rec_apb_master.sv
// APB3 requester for the cat_recognizer: turns a valid/ready command stream into
// single APB transfers and returns one response per command (data or timeout error).
module cat_rec_apb_master
    import cat_rec_pkg::*;
#(
    parameter int Amba_Word        = 24,
    parameter int Amba_Addr_Depth  = 13,
    parameter int Weight_precision = 5,
    parameter int Timeout_Cycles   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [Amba_Addr_Depth-1:0] cmd_addr,
    input  logic [Amba_Word-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [Amba_Word-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic [Amba_Addr_Depth-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Word-1:0]       PWDATA,
    input  logic [Amba_Word-1:0]       PRDATA,
    input  logic                       PREADY
);

    localparam int               CNT_W    = $clog2(Timeout_Cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Timeout_Cycles - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(Timeout_Cycles);

    // Weight data arrives pre-masked by the caller, so Weight_precision only bounds legality here.
    if (Timeout_Cycles < 1 || Weight_precision < 1 || Weight_precision > Amba_Word) begin : g_param_check
        $error("cat_rec_apb_master: illegal parameter combination");
    end

    apb_state_t                 state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [Amba_Addr_Depth-1:0] paddr_reg;
    logic                       pwrite_reg;
    logic [Amba_Word-1:0]       pwdata_reg;
    logic                       rsp_valid_reg, rsp_err_reg;
    logic [Amba_Word-1:0]       rsp_rdata_reg;
    logic                       accept, complete, abort;

    assign cmd_ready = (state_reg == APB_IDLE) ||
                       (state_reg == APB_ACCESS && PREADY && cnt_reg < CNT_MAX);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            APB_IDLE: begin
                if (accept) begin
                    state_next = APB_SETUP;
                    cnt_next   = '0;
                end
            end
            APB_SETUP: state_next = APB_ACCESS;
            APB_ACCESS: begin
                // PREADY takes priority over the timeout boundary.
                if (PREADY) begin
                    complete = 1'b1;
                    if (accept) begin
                        state_next = APB_SETUP;
                        cnt_next   = '0;
                    end else begin
                        state_next = APB_IDLE;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    abort      = 1'b1;
                    state_next = APB_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = APB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= APB_IDLE;
            cnt_reg       <= '0;
            paddr_reg     <= '0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                paddr_reg  <= cmd_addr;
                pwrite_reg <= cmd_write;
                pwdata_reg <= cmd_write ? cmd_wdata : '0;
            end
            rsp_valid_reg <= complete || abort;
            rsp_err_reg   <= abort;
            rsp_rdata_reg <= (complete && !pwrite_reg) ? PRDATA : '0;
        end
    end

    assign PSEL      = (state_reg != APB_IDLE);
    assign PENABLE   = (state_reg == APB_ACCESS);
    assign PADDR     = paddr_reg;
    assign PWRITE    = pwrite_reg;
    assign PWDATA    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_cat_rec_apb_master.sv
// Directed bench for cat_rec_apb_master: write, wait-state read, back-to-back,
// timeout abort, PREADY on the timeout boundary and reset during a transfer.
module tb_cat_rec_apb_master;
    import cat_rec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [12:0] cmd_addr = '0;
    logic [23:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [23:0] rsp_rdata;
    logic        rsp_err;
    logic [12:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [23:0] PWDATA;
    logic [23:0] PRDATA = '0;
    logic        PREADY = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    cat_rec_apb_master #(
        .Amba_Word(24), .Amba_Addr_Depth(13), .Weight_precision(5), .Timeout_Cycles(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 clk = ~clk;

    // Advance one clock; everything after returns is sampled 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_psel_penable: got %b%b want 00", PSEL, PENABLE); end
        n_checks++; if (PADDR !== 13'h0 || PWDATA !== 24'h0 || PWRITE !== 1'b0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h/%b want 0/0/0", PADDR, PWDATA, PWRITE); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 24'h0) begin n_fail++; $display("FAIL reset_rsp: got %b/%b/%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        rst = 1'b0;
        tick();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 1", cmd_ready); end
        $display("txn reset done");
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = WEIGHT_BASE; cmd_wdata = 24'h00ABCD; PREADY = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin n_fail++; $display("FAIL wr_accept: got ready=%b psel=%b want 1/0", cmd_ready, PSEL); end
        tick();
        cmd_valid = 1'b0; cmd_wdata = 24'h0;
        #1;
        n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_setup: got psel=%b pen=%b ready=%b want 1/0/0", PSEL, PENABLE, cmd_ready); end
        n_checks++; if (PADDR !== 13'h010 || PWRITE !== 1'b1 || PWDATA !== 24'h00ABCD) begin n_fail++; $display("FAIL wr_setup_bus: got %h/%b/%h want 010/1/00abcd", PADDR, PWRITE, PWDATA); end
        tick();
        n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_access: got psel=%b pen=%b rv=%b want 1/1/0", PSEL, PENABLE, rsp_valid); end
        n_checks++; if (PWDATA !== 24'h00ABCD) begin n_fail++; $display("FAIL wr_access_data: got %h want 00abcd", PWDATA); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 24'h0) begin n_fail++; $display("FAIL wr_rsp: got %b/%b/%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got %b%b want 00", PSEL, PENABLE); end
        $display("txn write addr=%h err=%0d rdata=%h", PADDR, rsp_err, rsp_rdata);
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_read_wait();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h1FFF; cmd_wdata = 24'hFFFFFF;
        PREADY = 1'b0; PRDATA = 24'hDEAD00;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (PADDR !== 13'h1FFF || PWRITE !== 1'b0 || PWDATA !== 24'h0) begin n_fail++; $display("FAIL rd_setup_bus: got %h/%b/%h want 1fff/0/0", PADDR, PWRITE, PWDATA); end
        tick();
        n_checks++; if (PENABLE !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rd_wait1: got pen=%b ready=%b want 1/0", PENABLE, cmd_ready); end
        tick();
        n_checks++; if (PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_wait2: got pen=%b rv=%b want 1/0", PENABLE, rsp_valid); end
        tick();
        PREADY = 1'b1; PRDATA = 24'h123456;
        #1;
        n_checks++; if (PENABLE !== 1'b1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_access3: got pen=%b ready=%b want 1/1", PENABLE, cmd_ready); end
        tick();
        PRDATA = 24'h0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 24'h123456) begin n_fail++; $display("FAIL rd_rsp: got %b/%b/%h want 1/0/123456", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (PSEL !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got psel=%b want 0", PSEL); end
        $display("txn read addr=%h err=%0d rdata=%h", PADDR, rsp_err, rsp_rdata);
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = IMAGE_BASE; cmd_wdata = 24'h000011; PREADY = 1'b1;
        tick();
        n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_setup_a: got %b/%b/%b want 1/0/0", PSEL, PENABLE, cmd_ready); end
        cmd_write = 1'b0; cmd_addr = STATUS_ADDR; cmd_wdata = 24'h0; PRDATA = 24'h00BEEF;
        tick();
        n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || cmd_ready !== 1'b1 || PADDR !== 13'h0400) begin n_fail++; $display("FAIL b2b_access_a: got %b/%b/%b/%h want 1/1/1/0400", PSEL, PENABLE, cmd_ready, PADDR); end
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 13'h0001 || PWRITE !== 1'b0) begin n_fail++; $display("FAIL b2b_setup_b: got %b/%b/%h/%b want 1/0/0001/0", PSEL, PENABLE, PADDR, PWRITE); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 24'h0) begin n_fail++; $display("FAIL b2b_rsp_a: got %b/%b/%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        $display("txn b2b write addr=0400 err=%0d rdata=%h", rsp_err, rsp_rdata);
        tick();
        n_checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_access_b: got %b/%b/%b want 1/1/0", PSEL, PENABLE, rsp_valid); end
        tick();
        PRDATA = 24'h0;
        n_checks++; if (PSEL !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 24'h00BEEF) begin n_fail++; $display("FAIL b2b_rsp_b: got psel=%b rv=%b rdata=%h want 0/1/00beef", PSEL, rsp_valid, rsp_rdata); end
        $display("txn b2b read addr=0001 err=%0d rdata=%h", rsp_err, rsp_rdata);
    endtask

    // Runs a read that waits 16 ACCESS cycles; ready_last raises PREADY on the 16th.
    task automatic run_timeout(input logic ready_last, input logic [23:0] last_data);
        int bad;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h0002; PREADY = 1'b0; PRDATA = 24'h777777;
        tick();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 15 && ready_last) begin
                cmd_valid = 1'b0; PREADY = 1'b1; PRDATA = last_data;
                #1;
            end
            if (PSEL !== 1'b1 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) bad++;
            if (cmd_ready !== (i == 15 && ready_last)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL to_access_cycles: got %0d bad ACCESS samples want 0", bad); end
        cmd_valid = 1'b0;
        tick();
        PREADY = 1'b0; PRDATA = 24'h0;
    endtask

    task automatic test_timeout();
        run_timeout(1'b0, 24'h0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 24'h0) begin n_fail++; $display("FAIL to_rsp: got %b/%b/%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b%b want 00", PSEL, PENABLE); end
        $display("txn timeout addr=%h err=%0d rdata=%h", PADDR, rsp_err, rsp_rdata);
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || PSEL !== 1'b0) begin n_fail++; $display("FAIL to_no_accept: got rv=%b psel=%b want 0/0", rsp_valid, PSEL); end
    endtask

    task automatic test_pready_at_boundary();
        run_timeout(1'b1, 24'h0C0FFE);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 24'h0C0FFE) begin n_fail++; $display("FAIL bnd_rsp: got %b/%b/%h want 1/0/0c0ffe", rsp_valid, rsp_err, rsp_rdata); end
        $display("txn boundary addr=%h err=%0d rdata=%h", PADDR, rsp_err, rsp_rdata);
    endtask

    task automatic test_reset_mid_transfer();
        int seen;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h0003; PREADY = 1'b0; PRDATA = 24'h555555;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_checks++; if (PENABLE !== 1'b1) begin n_fail++; $display("FAIL rst_pre_access: got pen=%b want 1", PENABLE); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PADDR !== 13'h0 || PWRITE !== 1'b0 || PWDATA !== 24'h0) begin n_fail++; $display("FAIL rst_mid_bus: got %b/%b/%h/%b/%h want all 0", PSEL, PENABLE, PADDR, PWRITE, PWDATA); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 24'h0) begin n_fail++; $display("FAIL rst_mid_rsp: got %b/%b/%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        seen = 0;
        PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_no_rsp: got %0d rsp_valid pulses want 0", seen); end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = CTRL_ADDR; cmd_wdata = 24'h000001;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (PSEL !== 1'b1 || PWDATA !== 24'h000001) begin n_fail++; $display("FAIL rst_recover_setup: got psel=%b pwdata=%h want 1/000001", PSEL, PWDATA); end
        tick(); tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_recover_rsp: got %b/%b want 1/0", rsp_valid, rsp_err); end
        $display("txn post-reset write addr=%h err=%0d", PADDR, rsp_err);
        PREADY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_pready_at_boundary();
        test_reset_mid_transfer();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
